// File: rtl/chunked_addsub_if.sv
// chunked_addsub_if: operand/result handshake bundle for chunked_addsub.
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : the adder itself (drives in_ready, results and busy)
// Signals: in_valid/in_ready, a, b, cin, sub (operand side);
//          out_valid/out_ready, sum, cout, ovf (result side); busy.
interface chunked_addsub_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/chunked_addsub.sv
// chunked_addsub: multi-cycle WIDTH-bit adder/subtractor built around a
// single CHUNK-bit ripple slice. Operands are captured on accept, then one
// chunk (LSB first) is added per clock with the carry held in a register.
// Subtraction is A + ~B + 1, the inversion being applied at capture time.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : chunked_addsub_if slave modport (operand and result handshakes,
//           sum/cout/ovf results, busy status)
module chunked_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  chunked_addsub_if.slave       bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [CHUNK-1:0] a_ch_s, b_ch_s, s_ch_s;
  logic             c_out_s;
  logic             c_msb_in_s;

  // Chunk selection and the CHUNK-bit ripple slice
  always_comb begin
    a_ch_s = '0;
    b_ch_s = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      a_ch_s = (idx_q == IDXW'(i)) ? op_a_q[i*CHUNK +: CHUNK] : a_ch_s;
      b_ch_s = (idx_q == IDXW'(i)) ? op_b_q[i*CHUNK +: CHUNK] : b_ch_s;
    end
    {c_out_s, s_ch_s} = {1'b0, a_ch_s} + {1'b0, b_ch_s} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the slice MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
    // On the last chunk this is the carry into bit WIDTH-1, needed for ovf.
    c_msb_in_s = a_ch_s[CHUNK-1] ^ b_ch_s[CHUNK-1] ^ s_ch_s[CHUNK-1];
  end

  // Next-state and next-output logic for the IDLE/RUN/DONE controller
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_a_d  = bus.a;
          op_b_d  = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int i = 0; i < NCHUNK; i++) begin
          sum_d[i*CHUNK +: CHUNK] = (idx_q == IDXW'(i)) ? s_ch_s : sum_q[i*CHUNK +: CHUNK];
        end
        carry_d = c_out_s;
        if (idx_q == LAST_IDX) begin
          cout_d  = c_out_s;
          ovf_d   = c_msb_in_s ^ c_out_s;
          idx_d   = idx_q;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDXW'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        // Results are frozen here; leaving DONE only returns to IDLE, so a
        // new accept is at least one cycle after out_valid falls.
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// tb_chunked_addsub: scoreboard bench for chunked_addsub in three shapes:
// (8,4) for directed cases, (16,1) and (8,8) for random sweeps.
module tb_chunked_addsub;

  logic clk;
  logic rst_n;

  chunked_addsub_if #(.WIDTH(8))  if0 ();
  chunked_addsub_if #(.WIDTH(16)) if1 ();
  chunked_addsub_if #(.WIDTH(8))  if2 ();

  chunked_addsub #(.WIDTH(8),  .CHUNK(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  chunked_addsub #(.WIDTH(16), .CHUNK(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  chunked_addsub #(.WIDTH(8),  .CHUNK(8)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  res_t sb0[$];
  res_t sb1[$];
  res_t sb2[$];

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports
  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide addition, overflow from operand/result signs
  function automatic res_t ref_calc(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input logic cin, input logic sub);
    logic [32:0] mask;
    logic [31:0] am, bb;
    logic [32:0] full;
    res_t r;
    mask = (33'd1 << w) - 33'd1;
    am   = a & mask[31:0];
    bb   = sub ? (~b & mask[31:0]) : (b & mask[31:0]);
    full = {1'b0, am} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : cin)};
    r.sum  = full[31:0] & mask[31:0];
    r.cout = full[w];
    r.ovf  = (am[w-1] == bb[w-1]) && (r.sum[w-1] != am[w-1]);
    return r;
  endfunction

  task automatic compare_res(input string tag, input logic [31:0] s, input logic c,
                             input logic o, input res_t e);
    check_val({tag, "_sum"},  64'(s), 64'(e.sum));
    check_val({tag, "_cout"}, 64'(c), 64'(e.cout));
    check_val({tag, "_ovf"},  64'(o), 64'(e.ovf));
  endtask

  // Result handshake on the (8,4) instance, then confirm back in IDLE
  task automatic hs0(input string tag);
    @(negedge clk);
    if0.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_val({tag, "_ov_drop"}, 64'(if0.out_valid), 64'd0);
    check_val({tag, "_rdy_back"}, 64'(if0.in_ready), 64'd1);
    check_val({tag, "_busy_drop"}, 64'(if0.busy), 64'd0);
    if0.out_ready = 1'b0;
  endtask

  // Directed transaction on the (8,4) instance with explicit expectations
  task automatic txn0(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic sub,
                      input logic [7:0] es, input logic ec, input logic eo);
    res_t e;
    int n;
    e.sum = 32'(es); e.cout = ec; e.ovf = eo;
    sb0.push_back(e);
    @(negedge clk);
    if0.a = a; if0.b = b; if0.cin = cin; if0.sub = sub; if0.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if0.in_valid = 1'b0;
    check_val({tag, "_busy"}, 64'(if0.busy), 64'd1);
    check_val({tag, "_rdy_low"}, 64'(if0.in_ready), 64'd0);
    n = 0;
    while (!if0.out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check_val({tag, "_lat"}, 64'(n), 64'd2);
    e = sb0.pop_front();
    compare_res(tag, 32'(if0.sum), if0.cout, if0.ovf, e);
    hs0(tag);
  endtask

  // Random sweep on the (16,1) instance
  task automatic sweep1(input int count);
    for (int i = 0; i < count; i++) begin
      logic [15:0] a, b;
      logic cin, sub;
      res_t e;
      int n;
      a = 16'($urandom); b = 16'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      sb1.push_back(ref_calc(16, 32'(a), 32'(b), cin, sub));
      @(negedge clk);
      if1.a = a; if1.b = b; if1.cin = cin; if1.sub = sub; if1.in_valid = 1'b1;
      @(posedge clk);
      #1;
      if1.in_valid = 1'b0;
      n = 0;
      while (!if1.out_valid && n < 100) begin
        @(posedge clk); #1; n++;
      end
      check_val("w16_lat", 64'(n), 64'd16);
      e = sb1.pop_front();
      compare_res("w16", 32'(if1.sum), if1.cout, if1.ovf, e);
      @(negedge clk);
      if1.out_ready = 1'b1;
      @(posedge clk);
      #1;
      if1.out_ready = 1'b0;
    end
  endtask

  // Random sweep on the (8,8) instance
  task automatic sweep2(input int count);
    for (int i = 0; i < count; i++) begin
      logic [7:0] a, b;
      logic cin, sub;
      res_t e;
      int n;
      a = 8'($urandom); b = 8'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      sb2.push_back(ref_calc(8, 32'(a), 32'(b), cin, sub));
      @(negedge clk);
      if2.a = a; if2.b = b; if2.cin = cin; if2.sub = sub; if2.in_valid = 1'b1;
      @(posedge clk);
      #1;
      if2.in_valid = 1'b0;
      n = 0;
      while (!if2.out_valid && n < 100) begin
        @(posedge clk); #1; n++;
      end
      check_val("w8c8_lat", 64'(n), 64'd1);
      e = sb2.pop_front();
      compare_res("w8c8", 32'(if2.sum), if2.cout, if2.ovf, e);
      @(negedge clk);
      if2.out_ready = 1'b1;
      @(posedge clk);
      #1;
      if2.out_ready = 1'b0;
    end
  endtask

  // Watchdog: the run must never hang
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Main stimulus sequence
  initial begin
    int n;
    rst_n = 1'b0;
    if0.in_valid = 1'b0; if0.a = '0; if0.b = '0; if0.cin = 1'b0; if0.sub = 1'b0; if0.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0; if1.sub = 1'b0; if1.out_ready = 1'b0;
    if2.in_valid = 1'b0; if2.a = '0; if2.b = '0; if2.cin = 1'b0; if2.sub = 1'b0; if2.out_ready = 1'b0;
    repeat (2) @(negedge clk);

    check_val("rst_sum", 64'(if0.sum), 64'd0);
    check_val("rst_cout", 64'(if0.cout), 64'd0);
    check_val("rst_ovf", 64'(if0.ovf), 64'd0);
    check_val("rst_ov", 64'(if0.out_valid), 64'd0);
    check_val("rst_rdy", 64'(if0.in_ready), 64'd1);
    check_val("rst_busy", 64'(if0.busy), 64'd0);
    rst_n = 1'b1;

    txn0("add1", 8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0);
    txn0("add2", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    txn0("add3", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    txn0("sub1", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    txn0("sub2", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Backpressure: hold DONE for 5 cycles while wiggling inputs
    @(negedge clk);
    if0.a = 8'h12; if0.b = 8'h34; if0.cin = 1'b0; if0.sub = 1'b0; if0.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if0.in_valid = 1'b0;
    n = 0;
    while (!if0.out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check_val("bp_lat", 64'(n), 64'd2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if0.in_valid = ~if0.in_valid;
      if0.a = 8'($urandom);
      if0.b = 8'($urandom);
      if0.sub = 1'($urandom);
      @(posedge clk);
      #1;
      check_val("bp_sum", 64'(if0.sum), 64'h46);
      check_val("bp_cout", 64'(if0.cout), 64'd0);
      check_val("bp_ovf", 64'(if0.ovf), 64'd0);
      check_val("bp_rdy", 64'(if0.in_ready), 64'd0);
      check_val("bp_ov", 64'(if0.out_valid), 64'd1);
    end
    @(negedge clk);
    if0.in_valid = 1'b0;
    hs0("bp");
    txn0("bp_next", 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset one cycle into RUN
    @(negedge clk);
    if0.a = 8'h3C; if0.b = 8'h0F; if0.cin = 1'b0; if0.sub = 1'b0; if0.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if0.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mrst_sum", 64'(if0.sum), 64'd0);
    check_val("mrst_cout", 64'(if0.cout), 64'd0);
    check_val("mrst_ovf", 64'(if0.ovf), 64'd0);
    check_val("mrst_ov", 64'(if0.out_valid), 64'd0);
    check_val("mrst_busy", 64'(if0.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("mrst_rdy", 64'(if0.in_ready), 64'd1);
    txn0("mrst_add", 8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0);

    sweep1(1000);
    sweep2(1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
